// File: rtl/sdrc_app_pkg.sv
// Shared types and default sizing for the SDRAM controller application front end.
package sdrc_app_pkg;

  localparam int APP_AW_DEF     = 30;
  localparam int APP_DW_DEF     = 32;
  localparam int LEN_W_DEF      = 9;
  localparam int CMD_DEPTH_DEF  = 4;
  localparam int DATA_DEPTH_DEF = 64;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    REQ,
    WDATA,
    RDATA
  } app_state_t;

  typedef struct packed {
    logic [APP_AW_DEF-1:0] addr;
    logic [LEN_W_DEF-1:0]  len;
    logic                  wr_n;
  } app_cmd_t;

endpackage

// File: rtl/sdrc_app_frontend_if.sv
// Host command/data channels and sdrc_core application request channel.
interface sdrc_app_frontend_if #(
  parameter int APP_AW = sdrc_app_pkg::APP_AW_DEF,
  parameter int APP_DW = sdrc_app_pkg::APP_DW_DEF,
  parameter int LEN_W  = sdrc_app_pkg::LEN_W_DEF
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [APP_AW-1:0]     cmd_addr;
  logic [LEN_W-1:0]      cmd_len;
  logic                  cmd_wr_n;
  logic                  wd_valid;
  logic                  wd_ready;
  logic [APP_DW-1:0]     wd_data;
  logic [APP_DW/8-1:0]   wd_be_n;
  logic                  rd_valid;
  logic [APP_DW-1:0]     rd_data;
  logic                  rd_last;
  logic                  app_req;
  logic [APP_AW-1:0]     app_req_addr;
  logic [LEN_W-1:0]      app_req_len;
  logic                  app_req_wr_n;
  logic                  app_req_dma_last;
  logic                  app_req_ack;
  logic [APP_DW-1:0]     app_wr_data;
  logic [APP_DW/8-1:0]   app_wr_en_n;
  logic                  app_wr_next_req;
  logic                  app_rd_valid;
  logic [APP_DW-1:0]     app_rd_data;
  logic                  app_last_rd;

  // master: the front end, which masters the core request bus
  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_wr_n,
    input  wd_valid, wd_data, wd_be_n,
    input  app_req_ack, app_wr_next_req, app_rd_valid, app_rd_data, app_last_rd,
    output cmd_ready, wd_ready, rd_valid, rd_data, rd_last,
    output app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_dma_last,
    output app_wr_data, app_wr_en_n
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_wr_n,
    output wd_valid, wd_data, wd_be_n,
    output app_req_ack, app_wr_next_req, app_rd_valid, app_rd_data, app_last_rd,
    input  cmd_ready, wd_ready, rd_valid, rd_data, rd_last,
    input  app_req, app_req_addr, app_req_len, app_req_wr_n, app_req_dma_last,
    input  app_wr_data, app_wr_en_n
  );
endinterface

// File: rtl/sdrc_sync_fifo.sv
// Single-clock show-ahead FIFO; pointers carry one extra bit to tell full from empty.
module sdrc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             do_push, do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && (count != '0);
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + CW'(1);
      if (do_pop)  rptr <= rptr + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/sdrc_app_frontend.sv
// Queues host commands and write data, issues one sdrc_core request at a time and checks read bursts.
module sdrc_app_frontend
  import sdrc_app_pkg::*;
#(
  parameter int APP_AW     = APP_AW_DEF,
  parameter int APP_DW     = APP_DW_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int CMD_DEPTH  = CMD_DEPTH_DEF,
  parameter int DATA_DEPTH = DATA_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                reset,
  sdrc_app_frontend_if.master bus,
  output logic                busy,
  output logic                err_zero_len,
  output logic                err_rd_short
);
  localparam int BE_W   = APP_DW / 8;
  localparam int CMD_W  = APP_AW + LEN_W + 1;
  localparam int DATA_W = APP_DW + BE_W;

  typedef struct packed {
    logic [APP_AW-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic              wr_n;
  } cmd_t;

  app_state_t state, state_n;
  cmd_t cmd_in, cmd_head;
  logic [DATA_W-1:0]             wd_head;
  logic [$clog2(CMD_DEPTH):0]    cmd_count;
  logic [$clog2(DATA_DEPTH):0]   data_count;
  logic cmd_full, data_full, cmd_empty, head_data_ok, data_ok;
  logic cmd_pop, wd_pop, ld_cmd, set_zero, set_short, app_req_q;
  logic [APP_AW-1:0] addr_q;
  logic [LEN_W-1:0]  len_q, rem, beat, beat_inc;
  logic              wr_n_q;

  assign cmd_in = {bus.cmd_addr, bus.cmd_len, bus.cmd_wr_n};

  sdrc_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .reset(reset), .push(bus.cmd_valid), .din(cmd_in), .pop(cmd_pop),
    .dout(cmd_head), .count(cmd_count), .full(cmd_full)
  );

  sdrc_sync_fifo #(.WIDTH(DATA_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk(clk), .reset(reset), .push(bus.wd_valid), .din({bus.wd_be_n, bus.wd_data}), .pop(wd_pop),
    .dout(wd_head), .count(data_count), .full(data_full)
  );

  assign cmd_empty    = (cmd_count == '0);
  assign head_data_ok = 32'(data_count) >= 32'(cmd_head.len);
  assign data_ok      = 32'(data_count) >= 32'(len_q);
  assign beat_inc     = beat + LEN_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // A write whose data is already buffered skips WAIT_DATA entirely.
  always_comb begin
    state_n   = state;
    cmd_pop   = 1'b0;
    wd_pop    = 1'b0;
    ld_cmd    = 1'b0;
    set_zero  = 1'b0;
    set_short = 1'b0;
    unique case (state)
      IDLE: if (!cmd_empty) begin
        cmd_pop = 1'b1;
        if (cmd_head.len == '0) begin
          set_zero = 1'b1;
        end else begin
          ld_cmd  = 1'b1;
          state_n = (cmd_head.wr_n || head_data_ok) ? REQ : WAIT_DATA;
        end
      end
      WAIT_DATA: if (data_ok) state_n = REQ;
      REQ: if (bus.app_req_ack) state_n = wr_n_q ? RDATA : WDATA;
      WDATA: if (bus.app_wr_next_req) begin
        wd_pop = 1'b1;
        if (rem == LEN_W'(1)) state_n = IDLE;
      end
      RDATA: if (bus.app_rd_valid) begin
        if (beat_inc == len_q) begin
          state_n = IDLE;
        end else if (bus.app_last_rd) begin
          set_short = 1'b1;
          state_n   = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= '0;
      len_q        <= '0;
      wr_n_q       <= 1'b1;
      rem          <= '0;
      beat         <= '0;
      app_req_q    <= 1'b0;
      err_zero_len <= 1'b0;
      err_rd_short <= 1'b0;
    end else begin
      app_req_q <= (state_n == REQ);
      if (ld_cmd) begin
        addr_q <= cmd_head.addr;
        len_q  <= cmd_head.len;
        wr_n_q <= cmd_head.wr_n;
      end
      if (state == REQ && bus.app_req_ack) begin
        rem  <= len_q;
        beat <= '0;
      end
      if (wd_pop) rem <= rem - LEN_W'(1);
      if (state == RDATA && bus.app_rd_valid) beat <= beat_inc;
      if (set_zero)  err_zero_len <= 1'b1;
      if (set_short) err_rd_short <= 1'b1;
    end
  end

  assign bus.cmd_ready        = !cmd_full;
  assign bus.wd_ready         = !data_full;
  assign bus.rd_valid         = bus.app_rd_valid;
  assign bus.rd_data          = bus.app_rd_data;
  assign bus.rd_last          = bus.app_last_rd;
  assign bus.app_req          = app_req_q;
  assign bus.app_req_dma_last = app_req_q;
  assign bus.app_req_addr     = addr_q;
  assign bus.app_req_len      = len_q;
  assign bus.app_req_wr_n     = wr_n_q;
  assign bus.app_wr_data      = (state == WDATA) ? wd_head[APP_DW-1:0] : '0;
  assign bus.app_wr_en_n      = (state == WDATA) ? wd_head[DATA_W-1:APP_DW] : '1;
  assign busy                 = (state != IDLE) || !cmd_empty;
endmodule

// File: tb/tb_sdrc_app_frontend.sv
// Randomised host/core bench for sdrc_app_frontend with a queue-based transaction model.
module tb_sdrc_app_frontend;
  import sdrc_app_pkg::*;

  localparam int AW = APP_AW_DEF;
  localparam int DW = APP_DW_DEF;
  localparam int LW = LEN_W_DEF;
  localparam int BW = DW / 8;
  typedef logic [BW+DW-1:0] word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic busy, err_zero_len, err_rd_short;

  always #5 clk = ~clk;

  sdrc_app_frontend_if #(.APP_AW(AW), .APP_DW(DW), .LEN_W(LW)) bus ();

  sdrc_app_frontend #(
    .APP_AW(AW), .APP_DW(DW), .LEN_W(LW), .CMD_DEPTH(4), .DATA_DEPTH(64)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .err_zero_len(err_zero_len), .err_rd_short(err_rd_short)
  );

  int checks = 0;
  int errors = 0;

  app_cmd_t host_cmd_q[$];
  app_cmd_t exp_req_q[$];
  word_t    host_wd_q[$];
  word_t    exp_wd_q[$];
  int       short_q[$];

  int cmd_pct, wd_pct, ack_pct, next_pct, rdv_pct, short_pct;
  bit topup;
  int mode;  // core model: 0 no burst, 1 write burst, 2 read burst
  int rem, beat, plan_end;
  bit req_checked, exp_zero, exp_short;
  int cyc, t_cmd_push, t_wd_push, t_req_rise, t_end, last_gap, req_cnt, wd_consumed, rd_seen;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic app_cmd_t mk_cmd(input logic [AW-1:0] a, input int l, input logic w);
    app_cmd_t c;
    c.addr = a;
    c.len  = LW'(l);
    c.wr_n = w;
    return c;
  endfunction

  task automatic drive_idle();
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.cmd_wr_n = 1'b1;
    bus.wd_valid = 1'b0; bus.wd_data = '0; bus.wd_be_n = '1;
    bus.app_req_ack = 1'b0; bus.app_wr_next_req = 1'b0;
    bus.app_rd_valid = 1'b0; bus.app_rd_data = '0; bus.app_last_rd = 1'b0;
  endtask

  task automatic model_reset();
    host_cmd_q.delete(); exp_req_q.delete(); host_wd_q.delete(); exp_wd_q.delete(); short_q.delete();
    mode = 0; req_checked = 1'b0; exp_zero = 1'b0; exp_short = 1'b0;
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_cmd_ready"}, bus.cmd_ready, 1);
    check({p, "_wd_ready"}, bus.wd_ready, 1);
    check({p, "_app_req"}, bus.app_req, 0);
    check({p, "_dma_last"}, bus.app_req_dma_last, 0);
    check({p, "_busy"}, busy, 0);
    check({p, "_err_zero"}, err_zero_len, 0);
    check({p, "_err_short"}, err_rd_short, 0);
    check({p, "_rd_valid"}, bus.rd_valid, 0);
    check({p, "_rd_last"}, bus.rd_last, 0);
    check({p, "_wr_en_n"}, bus.app_wr_en_n, 4'hF);
    check({p, "_req_addr"}, bus.app_req_addr, 0);
    check({p, "_req_len"}, bus.app_req_len, 0);
    check({p, "_req_wr_n"}, bus.app_req_wr_n, 1);
    check({p, "_wr_data"}, bus.app_wr_data, 0);
  endtask

  // One cycle: observe at the falling edge, play core and host, drive inputs for the next rising edge.
  task automatic tick();
    app_cmd_t c;
    word_t w;
    logic drv_rdv, drv_last;
    logic [DW-1:0] drv_rdd;
    @(negedge clk);
    cyc++;
    if (mode != 1) check("wr_en_idle", bus.app_wr_en_n, 4'hF);
    if (mode != 0) check("one_outstanding", bus.app_req, 0);
    bus.app_req_ack = 1'b0; bus.app_wr_next_req = 1'b0;
    drv_rdv = 1'b0; drv_last = 1'b0; drv_rdd = '0;
    case (mode)
      0: if (bus.app_req) begin
        if (!req_checked) begin
          req_checked = 1'b1;
          req_cnt++;
          t_req_rise = cyc;
          last_gap = cyc - t_end;
          if (exp_req_q.size() == 0) begin
            check("req_unexpected", 1, 0);
          end else begin
            c = exp_req_q[0];
            check("req_addr", bus.app_req_addr, c.addr);
            check("req_len", bus.app_req_len, c.len);
            check("req_wr_n", bus.app_req_wr_n, c.wr_n);
            check("req_dma_last", bus.app_req_dma_last, 1);
            if (!c.wr_n) check("wr_buffered", exp_wd_q.size() >= int'(c.len), 1);
          end
        end
        if (exp_req_q.size() != 0 && $urandom_range(99, 0) < ack_pct) begin
          c = exp_req_q.pop_front();
          bus.app_req_ack = 1'b1;
          req_checked = 1'b0;
          rem = int'(c.len);
          beat = 0;
          if (c.wr_n) begin
            mode = 2;
            if (short_q.size() != 0) plan_end = short_q.pop_front();
            else if (rem > 1 && $urandom_range(99, 0) < short_pct) plan_end = $urandom_range(rem - 1, 1);
            else plan_end = rem;
          end else begin
            mode = 1;
          end
        end
      end
      1: if ($urandom_range(99, 0) < next_pct) begin
        check("wr_avail", exp_wd_q.size() != 0, 1);
        if (exp_wd_q.size() != 0) begin
          w = exp_wd_q.pop_front();
          check("wr_data", bus.app_wr_data, w[DW-1:0]);
          check("wr_be_n", bus.app_wr_en_n, w[BW+DW-1:DW]);
        end
        bus.app_wr_next_req = 1'b1;
        wd_consumed++;
        rem--;
        if (rem == 0) begin mode = 0; t_end = cyc; end
      end
      2: if ($urandom_range(99, 0) < rdv_pct) begin
        beat++;
        drv_rdv = 1'b1;
        drv_rdd = DW'($urandom);
        if (beat == plan_end) begin
          drv_last = 1'b1;
          if (plan_end < rem) exp_short = 1'b1;
          mode = 0;
          t_end = cyc;
        end
      end
      default: mode = 0;
    endcase
    bus.app_rd_valid = drv_rdv; bus.app_rd_data = drv_rdd; bus.app_last_rd = drv_last;

    if (topup && host_wd_q.size() < 4) host_wd_q.push_back(word_t'({$urandom, $urandom}));
    bus.cmd_valid = 1'b0;
    if (host_cmd_q.size() != 0 && $urandom_range(99, 0) < cmd_pct) begin
      c = host_cmd_q[0];
      bus.cmd_valid = 1'b1; bus.cmd_addr = c.addr; bus.cmd_len = c.len; bus.cmd_wr_n = c.wr_n;
      if (bus.cmd_ready) begin
        void'(host_cmd_q.pop_front());
        t_cmd_push = cyc;
        if (c.len == '0) exp_zero = 1'b1;
        else exp_req_q.push_back(c);
      end
    end
    bus.wd_valid = 1'b0;
    if (host_wd_q.size() != 0 && $urandom_range(99, 0) < wd_pct) begin
      w = host_wd_q[0];
      bus.wd_valid = 1'b1; bus.wd_data = w[DW-1:0]; bus.wd_be_n = w[BW+DW-1:DW];
      if (bus.wd_ready) begin
        void'(host_wd_q.pop_front());
        t_wd_push = cyc;
        exp_wd_q.push_back(w);
      end
    end
    #1;
    check("rd_valid_pass", bus.rd_valid, drv_rdv);
    check("rd_data_pass", bus.rd_data, drv_rdd);
    check("rd_last_pass", bus.rd_last, drv_last);
    if (bus.rd_valid) rd_seen++;
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n = 0;
    while (!(host_cmd_q.size() == 0 && exp_req_q.size() == 0 && mode == 0 && !busy) && n < max_cyc) begin
      tick();
      n++;
    end
    check("drain_in_time", n < max_cyc, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n, base;
    drive_idle();
    model_reset();
    cmd_pct = 100; wd_pct = 100; ack_pct = 100; next_pct = 100; rdv_pct = 100; short_pct = 0;
    topup = 1'b0;
    cyc = 0; t_cmd_push = 0; t_wd_push = 0; t_req_rise = 0; t_end = 0; last_gap = 0;
    req_cnt = 0; wd_consumed = 0; rd_seen = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst");
    reset = 1'b0;
    tick();

    // single write, data buffered first
    for (int i = 0; i < 4; i++) host_wd_q.push_back({4'h0, 32'hA000_0000 + 32'(i)});
    repeat (6) tick();
    host_cmd_q.push_back(mk_cmd(30'h1_0000, 4, 1'b0));
    run_until_idle(50);
    check("wr_latency", t_req_rise - t_cmd_push, 2);
    check("wr_req_count", req_cnt, 1);

    // read passthrough
    rd_seen = 0;
    host_cmd_q.push_back(mk_cmd(30'h200, 5, 1'b1));
    run_until_idle(50);
    check("rd_latency", t_req_rise - t_cmd_push, 2);
    check("rd_beats", rd_seen, 5);
    check("rd_no_err", err_rd_short, 0);

    // write starved of data
    for (int i = 0; i < 5; i++) host_wd_q.push_back({4'(i), 32'hB000_0000 + 32'(i)});
    repeat (7) tick();
    n = req_cnt;
    host_cmd_q.push_back(mk_cmd(30'h300, 8, 1'b0));
    repeat (8) tick();
    check("starve_no_req", req_cnt, n);
    check("starve_busy", busy, 1);
    for (int i = 5; i < 8; i++) host_wd_q.push_back({4'(i), 32'hB000_0000 + 32'(i)});
    run_until_idle(60);
    check("starve_rise", t_req_rise - t_wd_push, 2);

    // short read followed by a queued read
    short_q.push_back(3);
    short_q.push_back(2);
    host_cmd_q.push_back(mk_cmd(30'h400, 5, 1'b1));
    host_cmd_q.push_back(mk_cmd(30'h480, 2, 1'b1));
    run_until_idle(60);
    check("short_err", err_rd_short, exp_short);
    check("short_err_set", err_rd_short, 1);
    check("b2b_gap", last_gap, 2);

    // zero length and a full command queue behind a stalled ack
    ack_pct = 0;
    host_cmd_q.push_back(mk_cmd(30'h500, 0, 1'b1));
    for (int i = 0; i < 5; i++) host_cmd_q.push_back(mk_cmd(30'h600 + 30'(i), i + 1, 1'b1));
    repeat (12) tick();
    check("cmd_full", bus.cmd_ready, 0);
    check("zero_err", err_zero_len, 1);
    check("queue_pending", exp_req_q.size(), 5);
    ack_pct = 100;
    run_until_idle(100);
    check("queue_ready", bus.cmd_ready, 1);

    // reset in the middle of a write burst
    for (int i = 0; i < 6; i++) host_wd_q.push_back({4'(i), 32'hC000_0000 + 32'(i)});
    host_cmd_q.push_back(mk_cmd(30'h700, 6, 1'b0));
    base = wd_consumed;
    n = 0;
    while (wd_consumed < base + 2 && n < 40) begin tick(); n++; end
    check("mid_reached", wd_consumed - base, 2);
    next_pct = 0;
    tick();
    check("mid_head_adv", bus.app_wr_en_n, 4'd2);
    reset = 1'b1;
    drive_idle();
    #1;
    check_reset_state("rst_mid");
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    next_pct = 100;
    n = req_cnt;
    host_cmd_q.push_back(mk_cmd(30'h800, 1, 1'b0));
    repeat (6) tick();
    check("rst_data_empty", req_cnt, n);
    host_wd_q.push_back({4'h9, 32'hD00D_F00D});
    run_until_idle(40);
    check("rst_recover", req_cnt, n + 1);

    // random traffic
    topup = 1'b1;
    for (int r = 0; r < 4; r++) begin
      cmd_pct = $urandom_range(100, 30); wd_pct = $urandom_range(100, 30);
      ack_pct = $urandom_range(100, 20); next_pct = $urandom_range(100, 20);
      rdv_pct = $urandom_range(100, 20); short_pct = 25;
      for (int k = 0; k < 150; k++) begin
        if (host_cmd_q.size() < 2)
          host_cmd_q.push_back(mk_cmd(AW'($urandom),
                                      ($urandom_range(9, 0) == 0) ? 0 : $urandom_range(12, 1),
                                      1'($urandom)));
        tick();
      end
      run_until_idle(3000);
    end
    check("final_err_zero", err_zero_len, exp_zero);
    check("final_err_short", err_rd_short, exp_short);
    check("final_busy", busy, 0);
    check("final_cmd_ready", bus.cmd_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
